// File: rtl/sync_tff_down_counter.sv
// Synchronous down counter built from per-bit toggle cells, with parallel
// load, count enable, free-running wrap mode and one-shot (stop-at-zero) mode.

// One count bit: a T flip-flop with a synchronous parallel-load path.
module sync_tff_down_counter_cell (
    input  logic clk,
    input  logic reset,
    input  logic t,
    input  logic ld,
    input  logic d,
    output logic q
);
    // Reset clears; load overrides toggle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            q <= 1'b0;
        else if (ld)
            q <= d;
        else if (t)
            q <= ~q;
    end
endmodule

module sync_tff_down_counter #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             mode,
    output logic [WIDTH-1:0] Q,
    output logic             zero,
    output logic             halted,
    output logic             wrap,
    output logic             done
);
    typedef enum logic {COUNT = 1'b0, HALT = 1'b1} state_t;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state, state_nxt;
    logic             dec;
    logic             wrap_nxt, done_nxt;
    logic [WIDTH-1:0] t;
    logic [WIDTH-1:0] q;

    assign Q      = q;
    assign zero   = (q == '0);
    assign halted = (state == HALT);

    // Borrow chain: a bit toggles when every lower bit is zero.
    assign t[0] = dec;
    genvar i;
    generate
        for (i = 1; i < WIDTH; i++) begin : g_chain
            assign t[i] = t[i-1] & ~q[i-1];
        end
        for (i = 0; i < WIDTH; i++) begin : g_cell
            sync_tff_down_counter_cell u_cell (
                .clk  (clk),
                .reset(reset),
                .t    (t[i]),
                .ld   (load),
                .d    (load_val[i]),
                .q    (q[i])
            );
        end
    endgenerate

    // State and pulse registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= HALT;
            wrap  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            wrap  <= wrap_nxt;
            done  <= done_nxt;
        end
    end

    // Next state, decrement qualify and pulse generation; load beats en.
    always_comb begin
        state_nxt = state;
        dec       = 1'b0;
        wrap_nxt  = 1'b0;
        done_nxt  = 1'b0;
        if (load) begin
            state_nxt = COUNT;
        end else if (en) begin
            if (!mode) begin
                dec       = 1'b1;
                state_nxt = COUNT;
                wrap_nxt  = zero;
            end else if (state == COUNT) begin
                if (zero) begin
                    // Loaded with zero: stop without a done pulse.
                    state_nxt = HALT;
                end else begin
                    dec = 1'b1;
                    if (q == ONE) begin
                        state_nxt = HALT;
                        done_nxt  = 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: doc/sync_tff_down_counter.md
Name: sync_tff_down_counter

Overview:
- Synchronous N-bit down counter built from per-bit toggle (T) flip-flop cells. It is the count-down counterpart of the team's synchronous T-FF up counter.
- Supports parallel load, count enable, and two modes: free-running wrap and one-shot.
- Used as a reload or timeout counter next to the up counters in the sequential-circuits library.

Parameters:
- WIDTH, 3, counter width in bits (>=2).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  count enable; one decrement per enabled clock.
- load  input  1  synchronous parallel load; has priority over en.
- load_val  input  WIDTH  value written to Q on load.
- mode  input  1  0 = wrap (free-running), 1 = one-shot (stop at zero).
- Q  output  WIDTH  current count.
- zero  output  1  combinational: Q == 0.
- halted  output  1  registered: state == HALT.
- wrap  output  1  registered one-cycle pulse on a 0 -> 2^WIDTH-1 transition.
- done  output  1  registered one-cycle pulse on a one-shot 1 -> 0 transition.

Behaviour:
- The clock is clk. The reset is asynchronous and active-high, on the port named reset.
- Count bits are WIDTH toggle cells. Bit i toggles when T_i = dec & ~Q[i-1] & ... & ~Q[0]; for bit 0, T_0 = dec. Here dec is the internal decrement-qualify signal.
  - Q must never be written as an arithmetic subtract.
  - The load path is a separate synchronous parallel write into the same cells.
- Reset (asynchronous, any time, including mid-count): Q=0, state=HALT, wrap=0, done=0. halted is therefore 1 and zero is 1.
- Two states: COUNT and HALT. Priority per edge: reset > load > en.
- load=1: Q<=load_val, state<=COUNT, wrap<=0, done<=0. en is ignored that cycle. This applies in either mode and either state.
- load=0, en=0: Q and state hold. wrap and done go to 0.
- load=0, en=1, mode=0:
  - dec=1 and Q<=Q-1 modulo 2^WIDTH. state<=COUNT, which also leaves HALT.
  - If Q was 0, Q becomes all-ones and wrap<=1 for exactly one cycle.
- load=0, en=1, mode=1, state=COUNT:
  - Q>1: dec=1, Q<=Q-1.
  - Q==1: dec=1, Q<=0, state<=HALT, done<=1 for one cycle.
  - Q==0 (e.g. after load of 0): dec=0, Q holds, state<=HALT, done stays 0.
- load=0, en=1, mode=1, state=HALT: Q holds, no pulses.
- wrap is never asserted in mode 1. done is never asserted in mode 0.
- Pulses are registered: each is high in the cycle after the edge that caused the transition, and low on the next edge unless retriggered. In mode 0, en held at Q==0 every 2^WIDTH cycles retriggers wrap.
- mode is sampled every edge and may change at any time. The new mode applies from that edge, with no flush.
- Latency:
  - Load to Q: 1 clock.
  - en to Q change: 1 clock.
  - zero is combinational from Q.
- Width rules: load_val is used at full width, with no truncation or extension. All-ones is 2^WIDTH-1.

Test Plan:
- Reset asserted mid-count (Q=5, en=1, asynchronous between edges) -> Q=0 immediately, halted=1, wrap=0, done=0. After release with mode=0, en=1 -> Q=7, wrap=1 one cycle, then Q=6,5,...
- mode=0, load 3, then en=1 for 10 clocks -> Q: 3,2,1,0,7,6,5,4,3,2. wrap high exactly one cycle, aligned with Q=7.
- mode=1, load 4, then en=1 for 6 clocks -> Q: 4,3,2,1,0,0. done high one cycle with Q=0, halted=1 after, Q stays 0.
- mode=1, HALT, load=1 and en=1 on the same edge with load_val=2 -> Q=2, state COUNT, no decrement that cycle; next en edge gives Q=1.
- en toggled 1,0,1,0 from Q=6, mode=0 -> Q: 5,5,4,4. The edge where en=1 and load=1 with load_val=0 yields Q=0, not 3.
- mode=1, load 0, en=1 -> Q holds 0, halted=1 after one clock, done never asserted. Then switch mode=0 with en=1 -> Q=7, wrap=1, halted=0.
